// File: rtl/ir_regfile_init_pkg.sv
// Shared definitions for the IR-indexed register file: FSM state codes and IR field positions.
package ir_regfile_init_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Low bit of each read-address field inside the instruction word
  localparam int IR_A_LSB = 8;
  localparam int IR_B_LSB = 4;

endpackage

// File: rtl/ir_regfile_init_regfile_core.sv
// Register storage with one write port and three combinational read ports; no reset on the data.
module regfile_core #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] wData,
  input  logic [AW-1:0]    rAddrA,
  input  logic [AW-1:0]    rAddrB,
  input  logic [AW-1:0]    rAddrC,
  output logic [WIDTH-1:0] rDataA,
  output logic [WIDTH-1:0] rDataB,
  output logic [WIDTH-1:0] rDataC
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rDataA = mem[rAddrA];
  assign rDataB = mem[rAddrB];
  assign rDataC = mem[rAddrC];

endmodule

// File: rtl/ir_regfile_init.sv
// Instruction register driving a register file that clears itself after reset.
// Define IRRF_BYPASS_EN for write-first forwarding on the read ports.
module ir_regfile_init
  import ir_regfile_init_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int AW       = 4,
  parameter int CR_INDEX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeIR,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] inpt,
  input  logic             writeRegFile,
  input  logic [AW-1:0]    WriteToReg,
  input  logic             CRwrite,
  output logic [WIDTH-1:0] IRout,
  output logic [WIDTH-1:0] DataA,
  output logic [WIDTH-1:0] DataB,
  output logic [WIDTH-1:0] DataCR,
  output logic             ready
);

  localparam logic [AW-1:0] CR_ADDR  = AW'(CR_INDEX);
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  logic [0:0]       state;
  logic [AW-1:0]    clrCnt;
  logic [WIDTH-1:0] ir;
  logic             userWrite;
  logic             coreWe;
  logic [AW-1:0]    coreAddr;
  logic [WIDTH-1:0] coreData;
  logic [AW-1:0]    addrA;
  logic [AW-1:0]    addrB;
  logic [WIDTH-1:0] rdA;
  logic [WIDTH-1:0] rdB;
  logic [WIDTH-1:0] rdC;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_INIT;
      clrCnt <= '0;
      ready  <= 1'b0;
      ir     <= '0;
    end else begin
      if (writeIR) ir <= instr;
      if (state == ST_INIT) begin
        clrCnt <= clrCnt + 1'b1;
        if (clrCnt == LAST_IDX) begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      end
    end
  end

  // The CR only accepts a write when both enables agree
  assign userWrite = (state == ST_RUN) && writeRegFile &&
                     ((WriteToReg != CR_ADDR) || CRwrite);

  assign coreWe   = (state == ST_INIT) || userWrite;
  assign coreAddr = (state == ST_INIT) ? clrCnt : WriteToReg;
  assign coreData = (state == ST_INIT) ? '0 : inpt;

  assign addrA = ir[IR_A_LSB +: AW];
  assign addrB = ir[IR_B_LSB +: AW];

  regfile_core #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) uCore (
    .clk   (clk),
    .we    (coreWe),
    .wAddr (coreAddr),
    .wData (coreData),
    .rAddrA(addrA),
    .rAddrB(addrB),
    .rAddrC(CR_ADDR),
    .rDataA(rdA),
    .rDataB(rdB),
    .rDataC(rdC)
  );

  assign IRout = ir;

`ifdef IRRF_BYPASS_EN
  // Clear-sweep writes are never forwarded, only accepted user writes
  assign DataA  = (userWrite && (WriteToReg == addrA))   ? inpt : rdA;
  assign DataB  = (userWrite && (WriteToReg == addrB))   ? inpt : rdB;
  assign DataCR = (userWrite && (WriteToReg == CR_ADDR)) ? inpt : rdC;
`else
  assign DataA  = rdA;
  assign DataB  = rdB;
  assign DataCR = rdC;
`endif

endmodule

// File: tb/tb_ir_regfile_init.sv
// Directed self-checking bench for ir_regfile_init (default parameters).
module tb_ir_regfile_init;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeIR;
  logic [15:0] instr;
  logic [15:0] inpt;
  logic        writeRegFile;
  logic [3:0]  WriteToReg;
  logic        CRwrite;
  logic [15:0] IRout;
  logic [15:0] DataA;
  logic [15:0] DataB;
  logic [15:0] DataCR;
  logic        ready;

  int nChecks = 0;
  int nPass   = 0;
  int initLen;

  ir_regfile_init dut (
    .clk         (clk),
    .reset       (reset),
    .writeIR     (writeIR),
    .instr       (instr),
    .inpt        (inpt),
    .writeRegFile(writeRegFile),
    .WriteToReg  (WriteToReg),
    .CRwrite     (CRwrite),
    .IRout       (IRout),
    .DataA       (DataA),
    .DataB       (DataB),
    .DataCR      (DataCR),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIR(input logic [15:0] v);
    instr   = v;
    writeIR = 1'b1;
    tick();
    writeIR = 1'b0;
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [15:0] d, input logic cr);
    WriteToReg   = a;
    inpt         = d;
    CRwrite      = cr;
    writeRegFile = 1'b1;
    tick();
    writeRegFile = 1'b0;
    CRwrite      = 1'b0;
  endtask

  // Counts sampled cycles with ready low, starting from the cycle after the reset edge
  task automatic countInit(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready) break;
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; writeIR = 1'b0; instr = '0; inpt = '0;
    writeRegFile = 1'b0; WriteToReg = '0; CRwrite = 1'b0;
    tick();
    tick();
    checkVal("reset_ready", {31'd0, ready}, 32'd0);
    checkVal("reset_ir", {16'd0, IRout}, 32'd0);

    // INIT sweep with user writes attempted and an IR load
    reset = 1'b0;
    writeRegFile = 1'b1; WriteToReg = 4'd0; inpt = 16'h1234;
    writeIR = 1'b1; instr = 16'h0A50;
    initLen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready) break;
      initLen++;
      tick();
      writeIR = 1'b0;
    end
    writeRegFile = 1'b0;
    checkVal("init_len", initLen, 32'd16);
    checkVal("init_ir_load", {16'd0, IRout}, 32'h0A50);
    checkVal("init_a_reg10", {16'd0, DataA}, 32'd0);
    checkVal("init_b_reg5", {16'd0, DataB}, 32'd0);
    checkVal("init_cr", {16'd0, DataCR}, 32'd0);
    setIR(16'h00F0);
    checkVal("init_a_reg0", {16'd0, DataA}, 32'd0);
    checkVal("init_b_reg15", {16'd0, DataB}, 32'd0);
    tick();
    checkVal("run_ready_stays", {31'd0, ready}, 32'd1);

    for (int i = 0; i <= 6; i++) writeReg(4'(i), 16'hF0F0 + 16'(i), 1'b0);
    for (int i = 0; i <= 5; i++) begin
      setIR(16'h0010 + 16'(i) * 16'h0110);
      checkVal($sformatf("seqA%0d", i), {16'd0, DataA}, 32'hF0F0 + i);
      checkVal($sformatf("seqB%0d", i), {16'd0, DataB}, 32'hF0F1 + i);
    end

    // CR write qualification
    writeReg(4'd8, 16'hABCD, 1'b0);
    checkVal("cr_no_qual", {16'd0, DataCR}, 32'd0);
    writeReg(4'd8, 16'hABCD, 1'b1);
    checkVal("cr_qual", {16'd0, DataCR}, 32'hABCD);
    WriteToReg = 4'd8; inpt = 16'h1111; CRwrite = 1'b1;
    tick();
    CRwrite = 1'b0;
    checkVal("cr_alone", {16'd0, DataCR}, 32'hABCD);
    writeReg(4'd2, 16'h2222, 1'b1);
    setIR(16'hF220);
    checkVal("same_a", {16'd0, DataA}, 32'h2222);
    checkVal("same_b", {16'd0, DataB}, 32'h2222);
    checkVal("ir_full", {16'd0, IRout}, 32'hF220);

    // Same-cycle read of a register being written
    setIR(16'h0300);
    checkVal("byp_before", {16'd0, DataA}, 32'hF0F3);
    WriteToReg = 4'd3; inpt = 16'h5A5A; writeRegFile = 1'b1;
    #1;
`ifdef IRRF_BYPASS_EN
    checkVal("byp_same_cycle", {16'd0, DataA}, 32'h5A5A);
`else
    checkVal("byp_same_cycle", {16'd0, DataA}, 32'hF0F3);
`endif
    tick();
    writeRegFile = 1'b0;
    checkVal("byp_after", {16'd0, DataA}, 32'h5A5A);
    WriteToReg = 4'd8; inpt = 16'h7777; writeRegFile = 1'b1; CRwrite = 1'b1;
    #1;
`ifdef IRRF_BYPASS_EN
    checkVal("byp_cr", {16'd0, DataCR}, 32'h7777);
`else
    checkVal("byp_cr", {16'd0, DataCR}, 32'hABCD);
`endif
    tick();
    writeRegFile = 1'b0; CRwrite = 1'b0;
    checkVal("cr_after", {16'd0, DataCR}, 32'h7777);

    // Reset from RUN, then again mid-INIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("rerun_ready", {31'd0, ready}, 32'd0);
    checkVal("rerun_ir", {16'd0, IRout}, 32'd0);
    for (int k = 0; k < 7; k++) tick();
    checkVal("mid_init_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    countInit(initLen);
    checkVal("restart_len", initLen, 32'd16);
    checkVal("restart_cr", {16'd0, DataCR}, 32'd0);
    setIR(16'h0320);
    checkVal("restart_a3", {16'd0, DataA}, 32'd0);
    checkVal("restart_b2", {16'd0, DataB}, 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
